// File: rtl/lut_accumulator.sv
// -----------------------------------------------------------------------------
// lut_accumulator
//
// Purpose:
//   Second stage of the ternary LUT matrix engine. Each accepted beat brings
//   a freshly registered 16-entry LUT of signed 16-bit partial sums and one
//   5-bit weight code per output column. The code selects a LUT entry
//   (bits 3:0) and optionally negates it (bit 4). Entries 14 and 15 are the
//   null codes and contribute zero. The selected, sign-corrected terms are
//   summed into saturating per-column accumulators over a run of len_i
//   beats. The column sums are then offered to the requantisation stage
//   through a valid/ready handshake.
//
// Ports:
//   clk            rising-edge system clock
//   rst_n_i        asynchronous active-low reset
//   start_i        run start pulse, honoured only in IDLE
//   len_i          number of beats in the run, latched on start
//   lut_entries_i  16 x signed 16-bit LUT, entry k at [16k+15:16k]
//   w_code_i       N_COL x 5-bit weight codes, column c at [5c+4:5c]
//   in_valid_i     LUT and codes are valid this cycle
//   in_ready_o     beat accepted this cycle; also enables the upstream register
//   acc_o          N_COL x signed ACC_W column sums, column c at [ACC_W*c +: ACC_W]
//   out_valid_o    acc_o holds a completed result
//   out_ready_i    downstream accepts the result
//   busy_o         a run is in progress (state is not IDLE)
//   sat_o          sticky: some column clamped during the current run
// -----------------------------------------------------------------------------
module lut_accumulator #(
    parameter int N_COL = 4,
    parameter int ACC_W = 32,   // must be 18 or more
    parameter int LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         len_i,
    input  logic [255:0]             lut_entries_i,
    input  logic [5*N_COL-1:0]       w_code_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [ACC_W*N_COL-1:0]   acc_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic                     sat_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W:0]          CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [LEN_W-1:0]        len_q;
    // One bit wider than len so that a run of 2^LEN_W-1 beats never wraps.
    logic [LEN_W:0]          cnt;
    logic [LEN_W:0]          cnt_inc;

    logic signed [ACC_W-1:0] acc     [N_COL];
    logic signed [ACC_W-1:0] acc_nxt [N_COL];
    logic signed [ACC_W-1:0] acc_out [N_COL];
    logic [N_COL-1:0]        clamp;
    logic                    sat;

    logic                    beat;
    logic                    last_beat;

    // -------------------------------------------------------------------------
    // Beat acceptance and end-of-run detection
    // -------------------------------------------------------------------------
    assign beat      = (state == ACC) && in_valid_i;
    assign cnt_inc   = cnt + CNT_ONE;
    assign last_beat = beat && (cnt_inc == {1'b0, len_q});

    // -------------------------------------------------------------------------
    // Per-column term selection and saturating add
    // -------------------------------------------------------------------------
    always_comb begin : lane_math
        logic [4:0]         code;
        logic [3:0]         idx;
        logic [15:0]        raw;
        logic signed [16:0] ent;
        logic signed [16:0] term;
        logic [ACC_W:0]     sum;
        // NOTE: every combinational variable gets a value before any branch,
        // so no path can leave one unassigned and infer a latch.
        code  = '0;
        idx   = '0;
        raw   = '0;
        ent   = '0;
        term  = '0;
        sum   = '0;
        clamp = '0;
        for (int c = 0; c < N_COL; c++) begin
            acc_nxt[c] = acc[c];
        end

        for (int c = 0; c < N_COL; c++) begin
            code = w_code_i[5*c +: 5];
            idx  = code[3:0];
            raw  = lut_entries_i[{idx, 4'b0000} +: 16];
            // Indices 14 and 15 are the null weight codes.
            ent  = (idx >= 4'd14) ? 17'sd0 : {raw[15], raw};
            // 17-bit negate so that -(-32768) is the exact +32768.
            term = code[4] ? -ent : ent;
            sum  = {acc[c][ACC_W-1], acc[c]} + {{(ACC_W-16){term[16]}}, term};
            // Overflow iff the two top bits of the widened sum disagree; the
            // top bit then gives the true sign of the result.
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                clamp[c]   = 1'b1;
                acc_nxt[c] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nxt[c] = sum[ACC_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (len_i == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // start_i is deliberately not looked at here.
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the accumulator and result arrays are small register banks, not
    // RAM, so they take the asynchronous reset like any other flop; a
    // mid-run reset must not leave a partial sum visible on acc_o.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_q <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            for (int c = 0; c < N_COL; c++) begin
                acc[c]     <= '0;
                acc_out[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q <= len_i;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        for (int c = 0; c < N_COL; c++) begin
                            acc[c]     <= '0;
                            acc_out[c] <= '0;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        cnt <= cnt_inc;
                        sat <= sat | (|clamp);
                        for (int c = 0; c < N_COL; c++) begin
                            acc[c] <= acc_nxt[c];
                        end
                        // Snapshot the final sums on the closing beat so the
                        // result is registered the moment out_valid_o rises.
                        if (last_beat) begin
                            for (int c = 0; c < N_COL; c++) begin
                                acc_out[c] <= acc_nxt[c];
                            end
                        end
                    end
                end
                default: begin
                    // DONE: result and flags are held for the consumer.
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready_o  = (state == ACC);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign sat_o       = sat;

    always_comb begin
        acc_o = '0;
        for (int c = 0; c < N_COL; c++) begin
            acc_o[ACC_W*c +: ACC_W] = acc_out[c];
        end
    end

endmodule

// File: tb/tb_lut_accumulator.sv
// -----------------------------------------------------------------------------
// tb_lut_accumulator
//
// Self-checking bench for lut_accumulator, built with an 18-bit accumulator so
// that saturation is reachable in a handful of beats. A behavioural model
// holds the expected column sums as plain integers and clamps with ordinary
// arithmetic; directed runs follow the test plan, followed by random runs
// with random bubbles, backpressure and stray start pulses.
// -----------------------------------------------------------------------------
module tb_lut_accumulator;

    localparam int N_COL = 4;
    localparam int ACC_W = 18;
    localparam int LEN_W = 16;
    localparam longint LIM_HI = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint LIM_LO = -(64'sd1 <<< (ACC_W-1));

    logic                    clk = 1'b0;
    logic                    rst_n_i;
    logic                    start_i;
    logic [LEN_W-1:0]        len_i;
    logic [255:0]            lut_entries_i;
    logic [5*N_COL-1:0]      w_code_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [ACC_W*N_COL-1:0]  acc_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    busy_o;
    logic                    sat_o;

    lut_accumulator #(
        .N_COL(N_COL),
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .lut_entries_i(lut_entries_i),
        .w_code_i     (w_code_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .acc_o        (acc_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .sat_o        (sat_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-beat stimulus for the current run.
    logic [255:0]       b_lut  [64];
    logic [5*N_COL-1:0] b_code [64];

    // Reference model state.
    longint m_acc [N_COL];
    bit     m_sat;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint col(input int c);
        logic signed [ACC_W-1:0] v;
        v = acc_o[ACC_W*c +: ACC_W];
        return longint'(v);
    endfunction

    function automatic logic [255:0] rand_lut();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
        return l;
    endfunction

    // Model of one accepted beat, straight from the arithmetic rules.
    task automatic model_beat(input logic [255:0] lut, input logic [5*N_COL-1:0] codes);
        for (int c = 0; c < N_COL; c++) begin
            int     idx;
            bit     neg;
            longint e;
            logic signed [15:0] raw;
            idx = int'(codes[5*c +: 4]);
            neg = codes[5*c+4];
            raw = lut[16*idx +: 16];
            e   = (idx >= 14) ? 0 : longint'(raw);
            if (neg) e = -e;
            m_acc[c] = m_acc[c] + e;
            if (m_acc[c] > LIM_HI) begin m_acc[c] = LIM_HI; m_sat = 1; end
            if (m_acc[c] < LIM_LO) begin m_acc[c] = LIM_LO; m_sat = 1; end
        end
    endtask

    task automatic check_result(input string tag);
        for (int c = 0; c < N_COL; c++) check($sformatf("%s_col%0d", tag, c), col(c), m_acc[c]);
        check({tag, "_sat"}, sat_o, m_sat);
    endtask

    // One complete run: start, feed len beats (optionally with bubbles and
    // stray start pulses), hold the result under backpressure, handshake.
    task automatic run(input int len, input bit bubbles, input int bp, input bit poke);
        int n;
        int cyc;
        bit v;
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < N_COL; c++) m_acc[c] = 0;
        m_sat = 0;
        check("busy_after_start", busy_o, 1);

        n   = 0;
        cyc = 0;
        while (n < len) begin
            v = !bubbles || (cyc % 2 == 0);
            check("in_ready_acc", in_ready_o, 1);
            in_valid_i    = v;
            lut_entries_i = v ? b_lut[n]  : rand_lut();
            w_code_i      = v ? b_code[n] : (5*N_COL)'($urandom());
            start_i       = poke && ($urandom_range(0, 2) == 0);
            if (start_i) len_i = LEN_W'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (v) begin
                model_beat(b_lut[n], b_code[n]);
                n++;
            end
            cyc++;
        end
        in_valid_i = 1'b0;
        start_i    = 1'b0;

        // First cycle after the closing edge: the result is already up.
        check("out_valid_rise", out_valid_o, 1);
        check("in_ready_done", in_ready_o, 0);
        check_result("result");

        for (int i = 0; i < bp; i++) begin
            out_ready_i   = 1'b0;
            start_i       = poke;
            in_valid_i    = 1'b1;
            lut_entries_i = rand_lut();
            w_code_i      = (5*N_COL)'($urandom());
            @(posedge clk); #1;
            check("bp_out_valid", out_valid_o, 1);
            check("bp_in_ready", in_ready_o, 0);
            for (int c = 0; c < N_COL; c++) check($sformatf("bp_hold_col%0d", c), col(c), m_acc[c]);
        end
        in_valid_i = 1'b0;

        // Handshake; a start in the same cycle must be ignored.
        out_ready_i = 1'b1;
        start_i     = poke;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        check("hs_out_valid", out_valid_o, 0);
        check("hs_busy", busy_o, 0);
        check_result("after_hs");
        @(posedge clk); #1;
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] l;
        rst_n_i       = 1'b0;
        start_i       = 1'b0;
        len_i         = '0;
        lut_entries_i = '0;
        w_code_i      = '0;
        in_valid_i    = 1'b0;
        out_ready_i   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_acc", longint'(acc_o[63:0]) | longint'(acc_o[71:64]), 0);
        rst_n_i = 1'b1;
        @(posedge clk); #1;

        // Basic accumulation: entry k = 10k, codes {9,12,3,0}.
        for (int k = 0; k < 16; k++) l[16*k +: 16] = 16'(10*k);
        for (int i = 0; i < 3; i++) begin
            b_lut[i]  = l;
            b_code[i] = {5'd0, 5'd3, 5'd12, 5'd9};
        end
        run(3, 0, 0, 0);
        check("basic_c0", col(0), 270);
        check("basic_c1", col(1), 360);
        check("basic_c2", col(2), 90);
        check("basic_c3", col(3), 0);

        // Negation, -(-32768), and null codes.
        for (int i = 0; i < 2; i++) begin
            l = rand_lut();
            l[16*13 +: 16] = 16'd100;
            l[16*9  +: 16] = 16'h8000;
            b_lut[i]  = l;
            b_code[i] = {5'h1F, 5'h0E, 5'h19, 5'h1D};
        end
        run(2, 0, 0, 0);
        check("neg_c0", col(0), -200);
        check("neg_c1", col(1), 65536);
        check("neg_c2", col(2), 0);
        check("neg_sat", sat_o, 0);

        // Bubbles on the input, 5 cycles of backpressure on the output.
        for (int i = 0; i < 4; i++) begin
            b_lut[i]  = rand_lut();
            b_code[i] = (5*N_COL)'($urandom());
        end
        run(4, 1, 5, 0);

        // Positive and negative saturation.
        for (int i = 0; i < 10; i++) begin
            l = rand_lut();
            l[16*13 +: 16] = 16'd32767;
            b_lut[i]  = l;
            b_code[i] = {4{5'h0D}};
        end
        run(10, 0, 0, 0);
        check("satp_c0", col(0), 131071);
        check("satp_flag", sat_o, 1);
        for (int i = 0; i < 10; i++) b_code[i] = {4{5'h1D}};
        run(10, 0, 0, 0);
        check("satn_c3", col(3), -131072);
        check("satn_flag", sat_o, 1);

        // Zero-length run with stray starts in DONE.
        run(0, 0, 3, 1);
        check("len0_c1", col(1), 0);

        // Stray starts during ACC.
        for (int i = 0; i < 5; i++) begin
            b_lut[i]  = rand_lut();
            b_code[i] = (5*N_COL)'($urandom());
        end
        run(5, 1, 2, 1);

        // Reset in the middle of a run.
        for (int i = 0; i < 5; i++) begin
            b_lut[i]  = rand_lut();
            b_code[i] = (5*N_COL)'($urandom());
        end
        start_i = 1'b1;
        len_i   = 16'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i    = 1'b1;
            lut_entries_i = b_lut[i];
            w_code_i      = b_code[i];
            @(posedge clk); #1;
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_in_ready", in_ready_o, 0);
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_sat", sat_o, 0);
        for (int c = 0; c < N_COL; c++) check($sformatf("midrst_col%0d", c), col(c), 0);
        in_valid_i = 1'b0;
        @(posedge clk); #2;
        rst_n_i = 1'b1;
        @(posedge clk); #1;
        b_lut[0]  = rand_lut();
        b_code[0] = (5*N_COL)'($urandom());
        run(1, 0, 1, 0);

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                b_lut[i]  = rand_lut();
                b_code[i] = (5*N_COL)'($urandom());
            end
            run(len, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lut_accumulator.md
Name: lut_accumulator

Overview:
- Consumes the registered 16-entry ternary LUT produced each cycle by the preprocessing stage.
- Selects one entry per output column using a 5-bit ternary weight code: bit 4 is the negate flag and bits 3:0 are the entry index.
- Accumulates the selected, sign-corrected values over a run-time number of activation groups into saturating per-column accumulators.
- Presents the final column sums through a valid/ready output handshake for the downstream requantisation stage.

Parameters:
- N_COL, 4, number of output columns (weight codes) processed per beat.
- ACC_W, 32, accumulator width per column in bits (signed, two's complement); must be 18 or more.
- LEN_W, 16, width of the group-count input.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n_i, input, 1, asynchronous active-low reset.
- start_i, input, 1, single-cycle pulse that starts a run; sampled only in IDLE.
- len_i, input, LEN_W, number of LUT beats to accumulate; latched when start_i is accepted.
- lut_entries_i, input, 256, 16 signed 16-bit entries; entry k occupies bits [16k+15:16k].
- w_code_i, input, 5*N_COL, weight code for column c occupies bits [5c+4:5c].
- in_valid_i, input, 1, lut_entries_i and w_code_i are valid this cycle.
- in_ready_o, output, 1, block accepts a beat this cycle; also drives the preprocessing stage's register enable.
- acc_o, output, ACC_W*N_COL, final column sums; column c occupies bits [ACC_W*c+ACC_W-1:ACC_W*c].
- out_valid_o, output, 1, acc_o holds a completed result.
- out_ready_i, input, 1, downstream accepts the result.
- busy_o, output, 1, high whenever the state is not IDLE.
- sat_o, output, 1, sticky flag: at least one column saturated during the current run.

Behaviour:
- Reset (asynchronous, rst_n_i=0) forces:
  - state = IDLE
  - all accumulators, acc_o, and the beat counter = 0
  - in_ready_o = 0, out_valid_o = 0, busy_o = 0, sat_o = 0
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready_o = 0.
  - On start_i=1: latch len_i, clear the accumulators, the beat counter and sat_o.
  - If len_i = 0, go to DONE (the result is all zeros); otherwise go to ACC.
- ACC:
  - in_ready_o = 1. A beat is accepted on any cycle where in_valid_i=1.
  - start_i is ignored in this state.
  - For each column c, per accepted beat:
    - idx = code[3:0]; e = lut_entries_i[idx] sign-extended to 17 bits.
    - Index values 14 and 15 force e = 0.
    - If code[4] = 1, e = -e, computed at 17 bits so that -(-32768) = +32768 exactly.
    - The term is sign-extended to ACC_W+1 bits and added to the accumulator.
    - The sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets sat_o.
  - Accumulators update on the clock edge that accepts the beat, so there is 1 cycle of latency per beat.
  - The beat counter increments on every accepted beat. When the accepted beat is number len, the next state is DONE.
  - A cycle with in_valid_i=0 leaves all state unchanged.
- DONE:
  - out_valid_o = 1, in_ready_o = 0.
  - acc_o equals the accumulators; acc_o is a registered copy and is held stable while out_ready_i = 0.
  - out_valid_o rises on the first cycle after the edge that accepted the last beat.
  - On out_valid_o and out_ready_i both high: go to IDLE and deassert out_valid_o the next cycle. acc_o and sat_o hold their values until the next start.
  - start_i is ignored in DONE, including when it arrives in the same cycle as the handshake; a new run needs a start pulse while in IDLE.
- Reset asserted mid-run aborts immediately and returns to the reset values above; no partial result is emitted.
- The counter is LEN_W+1 bits wide internally, so len_i = 2^LEN_W-1 completes without wrap-around.

Test Plan:
- Basic accumulation: len=3, entries = k*10 for each k, codes {9,12,3,0} on every beat → acc_o = {270,360,90,0}; out_valid_o rises 1 cycle after the 3rd accepted beat.
- Negation and null codes: len=2, entry13 = 100, entry9 = -32768, codes {0x1D,0x19,0x0E,0x1F} → acc_o = {-200,65536,0,0}; sat_o = 0.
- Input bubbles and output backpressure: len=4 with in_valid_i toggled on alternate cycles, then out_ready_i held low for 5 cycles → exactly 4 beats summed; acc_o stable and out_valid_o held until the handshake; in_ready_o = 0 throughout DONE.
- Saturation: ACC_W=18, len=10, entry13 = 32767, code 0x0D → acc_o = 131071 and sat_o = 1; with code 0x1D → acc_o = -131072 and sat_o = 1.
- len=0 start → DONE on the next cycle with all-zero acc_o; no beats are consumed; start_i pulses during ACC and DONE are ignored.
- Reset mid-run: assert rst_n_i low after 2 of 5 beats → all outputs return to 0 asynchronously; a fresh len=1 run afterwards produces only that run's value.
